// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the two-road signal controller.
// Lamp vectors are {R,Y,G}; road A occupies the upper three bits.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      A_GREEN  = 3'd0,
      A_YELLOW = 3'd1,
      AB_RED   = 3'd2,
      B_GREEN  = 3'd3,
      B_YELLOW = 3'd4,
      BA_RED   = 3'd5
   } tl_state_e;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [5:0] LAMPS_A_GREEN  = {LAMP_G, LAMP_R};
   localparam logic [5:0] LAMPS_A_YELLOW = {LAMP_Y, LAMP_R};
   localparam logic [5:0] LAMPS_ALL_RED  = {LAMP_R, LAMP_R};
   localparam logic [5:0] LAMPS_B_GREEN  = {LAMP_R, LAMP_G};
   localparam logic [5:0] LAMPS_B_YELLOW = {LAMP_R, LAMP_Y};

   function automatic int tl_timer_w(
      input int g,
      input int y,
      input int a
   );
      int m;
      m = g;
      if (y > m) m = y;
      if (a > m) m = a;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Saturating phase counter; cleared on the edge that changes state.
module tl_phase_timer
   import traffic_light_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (r_count != '1) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road intersection controller: A rests green, B served on request.
// Lamps decode from the state register only.
module traffic_light_controller
   import traffic_light_pkg::*;
#(
   parameter int GREEN_MIN    = 8,
   parameter int YELLOW_TIME  = 3,
   parameter int ALL_RED_TIME = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic Sa,
   input  logic Sb,
   output logic Ra,
   output logic Ya,
   output logic Ga,
   output logic Rb,
   output logic Yb,
   output logic Gb
);

   localparam int TW =
      tl_timer_w(GREEN_MIN, YELLOW_TIME, ALL_RED_TIME);

   localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_TIME - 1);
   localparam logic [TW-1:0] T_RED    = TW'(ALL_RED_TIME - 1);

   tl_state_e     r_state;
   tl_state_e     w_next;
   logic [TW-1:0] w_t;
   logic          r_req_a;
   logic          r_req_b;
   logic          w_set_a;
   logic          w_set_b;
   logic          w_clr_a;
   logic          w_clr_b;
   logic [5:0]    w_lamps;

   tl_phase_timer #(
      .W (TW)
   ) u_timer (
      .clk     (clk),
      .rst_n   (reset),
      .i_clr   (w_next != r_state),
      .o_count (w_t)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= A_GREEN;
      end else begin
         r_state <= w_next;
      end
   end

   // A request only latches for the road that is not green or next green.
   assign w_set_a = Sa &&
      (r_state inside {B_GREEN, A_YELLOW, AB_RED});
   assign w_set_b = Sb &&
      (r_state inside {A_GREEN, B_YELLOW, BA_RED});
   assign w_clr_a = (r_state == BA_RED) && (w_next == A_GREEN);
   assign w_clr_b = (r_state == AB_RED) && (w_next == B_GREEN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req_a <= 1'b0;
         r_req_b <= 1'b0;
      end else begin
         r_req_a <= w_clr_a ? 1'b0 : (r_req_a | w_set_a);
         r_req_b <= w_clr_b ? 1'b0 : (r_req_b | w_set_b);
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         A_GREEN:
            if (w_t >= T_GREEN && (r_req_b || Sb))
               w_next = A_YELLOW;
         A_YELLOW:
            if (w_t == T_YELLOW) w_next = AB_RED;
         AB_RED:
            if (w_t == T_RED) w_next = B_GREEN;
         B_GREEN:
            if (w_t >= T_GREEN && (r_req_a || Sa))
               w_next = B_YELLOW;
         B_YELLOW:
            if (w_t == T_YELLOW) w_next = BA_RED;
         BA_RED:
            if (w_t == T_RED) w_next = A_GREEN;
         default:
            w_next = A_GREEN;
      endcase
   end

   always_comb begin
      w_lamps = LAMPS_ALL_RED;
      unique case (r_state)
         A_GREEN:  w_lamps = LAMPS_A_GREEN;
         A_YELLOW: w_lamps = LAMPS_A_YELLOW;
         AB_RED:   w_lamps = LAMPS_ALL_RED;
         B_GREEN:  w_lamps = LAMPS_B_GREEN;
         B_YELLOW: w_lamps = LAMPS_B_YELLOW;
         BA_RED:   w_lamps = LAMPS_ALL_RED;
         default:  w_lamps = LAMPS_ALL_RED;
      endcase
   end

   assign {Ra, Ya, Ga, Rb, Yb, Gb} = w_lamps;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: a schedule-based road model predicts the lamps
// each cycle; a monitor pops and compares after every rising edge.
module tb_traffic_light_controller;

   localparam int GMIN = 8;
   localparam int YT   = 3;
   localparam int ART  = 1;

   localparam logic [5:0] AG = 6'b001100;
   localparam logic [5:0] AY = 6'b010100;
   localparam logic [5:0] RR = 6'b100100;
   localparam logic [5:0] BG = 6'b100001;
   localparam logic [5:0] BY = 6'b100010;

   logic clk = 1'b0;
   logic reset;
   logic Sa;
   logic Sb;
   logic Ra, Ya, Ga, Rb, Yb, Gb;
   logic [5:0] lamps;

   int total = 0;
   int bad   = 0;

   traffic_light_controller #(
      .GREEN_MIN    (GMIN),
      .YELLOW_TIME  (YT),
      .ALL_RED_TIME (ART)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .Sa    (Sa),
      .Sb    (Sb),
      .Ra    (Ra),
      .Ya    (Ya),
      .Ga    (Ga),
      .Rb    (Rb),
      .Yb    (Yb),
      .Gb    (Gb)
   );

   assign lamps = {Ra, Ya, Ga, Rb, Yb, Gb};

   always #5 clk = ~clk;

   task automatic chk(
      input string      nm,
      input logic [5:0] act,
      input logic [5:0] exp
   );
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Road model: which road owns green, how long it has been
   // green, pending requests, and a queue of upcoming lamp patterns.
   int         m_g;
   bit         m_in_green;
   int         m_age;
   bit         m_pend [2];
   logic [5:0] m_cur;
   logic [5:0] m_sched [$];
   logic [5:0] exp_q [$];

   function automatic logic [5:0] grn(input int r);
      return (r == 0) ? AG : BG;
   endfunction

   function automatic logic [5:0] yel(input int r);
      return (r == 0) ? AY : BY;
   endfunction

   task automatic m_reset();
      m_g        = 0;
      m_in_green = 1'b1;
      m_age      = 0;
      m_pend[0]  = 1'b0;
      m_pend[1]  = 1'b0;
      m_cur      = AG;
      m_sched.delete();
   endtask

   task automatic m_step(input bit sa, input bit sb);
      bit s [2];
      int lr;
      s[0] = sa;
      s[1] = sb;
      lr = m_in_green ? 1 - m_g : m_g;
      if (s[lr]) m_pend[lr] = 1'b1;
      if (m_in_green) begin
         if (m_age >= GMIN - 1 && m_pend[1 - m_g]) begin
            repeat (YT) m_sched.push_back(yel(m_g));
            repeat (ART) m_sched.push_back(RR);
            m_sched.push_back(grn(1 - m_g));
            m_cur = m_sched.pop_front();
            m_in_green = 1'b0;
         end else begin
            m_age++;
         end
      end else begin
         m_cur = m_sched.pop_front();
         if (m_sched.size() == 0) begin
            m_g = 1 - m_g;
            m_in_green = 1'b1;
            m_age = 0;
            m_pend[m_g] = 1'b0;
         end
      end
   endtask

   always @(posedge clk) begin
      if (!reset) m_reset();
      else m_step(Sa, Sb);
      exp_q.push_back(m_cur);
   end

   always @(posedge clk) begin
      logic [5:0] e;
      #1;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL sb_empty: got %b want entry", lamps);
      end else begin
         e = exp_q.pop_front();
         chk("lamps", lamps, e);
      end
      total++;
      if (Ga && Gb) begin
         bad++;
         $display("FAIL both_green: got %b want not 1", Ga & Gb);
      end
      total++;
      if (($countones({Ra, Ya, Ga}) != 1) ||
          ($countones({Rb, Yb, Gb}) != 1)) begin
         bad++;
         $display("FAIL one_lamp: got %b want one per road", lamps);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         Sa = 1'b0;
         Sb = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic a, input logic b);
      Sa = a;
      Sb = b;
      @(negedge clk);
      Sa = 1'b0;
      Sb = 1'b0;
   endtask

   initial begin
      bit found;
      reset = 1'b0;
      Sa    = 1'b0;
      Sb    = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_hold", lamps, AG);
      reset = 1'b1;

      idle(50);
      pulse(1'b0, 1'b1);
      idle(25);
      pulse(1'b1, 1'b0);
      idle(25);

      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(2);
      pulse(1'b0, 1'b1);
      idle(20);

      pulse(1'b1, 1'b0);
      idle(20);
      pulse(1'b1, 1'b1);
      idle(30);

      pulse(1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (Yb) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL wait_byellow: got timeout want Yb");
      end
      Sb = 1'b1;
      @(posedge clk);
      #3;
      reset = 1'b0;
      Sb = 1'b0;
      #1;
      chk("async_reset", lamps, AG);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(30);

      for (int i = 0; i < 400; i++) begin
         Sa = ($urandom_range(0, 9) == 0);
         Sb = ($urandom_range(0, 9) == 0);
         @(negedge clk);
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Two-road intersection signal controller driving red/yellow/green lamps for road A (main) and road B (side). Road A rests on green. A one-cycle request pulse from the opposite road's sensor/button is latched and served after a minimum-green interval, a yellow interval and an all-red clearance. It sits between debounced sensor inputs and the lamp drivers.

## Interface
Parameters:
- GREEN_MIN, default 8: minimum green duration in cycles (≥1).
- YELLOW_TIME, default 3: yellow duration in cycles (≥1).
- ALL_RED_TIME, default 1: all-red clearance duration in cycles (≥1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- Sa  input  1  road A request, sampled on rising clk; a single-cycle pulse suffices.
- Sb  input  1  road B request, same rules as Sa.
- Ra, Ya, Ga  output  1 each  road A red/yellow/green lamps.
- Rb, Yb, Gb  output  1 each  road B red/yellow/green lamps.

## Operation
- States: A_GREEN, A_YELLOW, AB_RED, B_GREEN, B_YELLOW, BA_RED.
- Lamp decode (function of state register only, no input paths):
  - A_GREEN: Ga, Rb.
  - A_YELLOW: Ya, Rb.
  - AB_RED / BA_RED: Ra, Rb.
  - B_GREEN: Ra, Gb.
  - B_YELLOW: Ra, Yb.
- Exactly one lamp per road is lit at all times. Ga and Gb are never both 1. A green always has the other road red.
- Request latches reqA, reqB:
  - reqB is set on any edge where Sb=1 and state≠B_GREEN. It clears on the edge entering B_GREEN. reqA is symmetric.
  - A request for the road already green is ignored.
- Phase timer counts cycles in the current state: 0 on entry, +1 per cycle, saturating.
- Transitions (t = timer value):
  - A_GREEN→A_YELLOW when t ≥ GREEN_MIN−1 and (reqB or Sb). Otherwise A_GREEN holds indefinitely.
  - A_YELLOW→AB_RED when t = YELLOW_TIME−1.
  - AB_RED→B_GREEN when t = ALL_RED_TIME−1.
  - B_GREEN→B_YELLOW when t ≥ GREEN_MIN−1 and (reqA or Sa). B green rests indefinitely if A never requests.
  - B_YELLOW→BA_RED and BA_RED→A_GREEN are symmetric to the A-side transitions.
- Once yellow has started, the switch is committed. Requests arriving during yellow or all-red are latched only for the road not about to go green.
- Simultaneous Sa and Sb in A_GREEN: Sb latched, Sa ignored.

## Timing
- Reset asserted (reset=0), taking effect immediately and asynchronously:
  - state=A_GREEN, timer=0, reqA=reqB=0.
  - Outputs: Ga=1, Rb=1, all others 0.
- Release is synchronous-safe: the first transition is evaluated on the first rising edge after reset=1.
- Request to lamp change: a request held pending while green has run ≥ GREEN_MIN cycles changes lamps on the next rising edge (1-cycle latency).
- Full A→B handover: yellow for exactly YELLOW_TIME cycles, then all-red for exactly ALL_RED_TIME cycles, then B green.
- Reset mid-sequence (any state) aborts immediately to A_GREEN with latches cleared.

## Structure
- Package traffic_light_pkg:
  - state enum tl_state_e.
  - Lamp-vector constants {R,Y,G} per state.
  - Timer width helper: $clog2 of max(GREEN_MIN, YELLOW_TIME, ALL_RED_TIME)+1.
- Sub-module tl_phase_timer: saturating counter with a clear-on-state-change input and a count output.
- Top module: state register, request latches, next-state logic, lamp decode.

## Test plan
(All scenarios use default parameters.)
- Reset: hold reset=0 for 2 cycles → Ga=1, Rb=1, others 0. After release with no requests, A_GREEN persists for 50 cycles.
- Early Sb pulse: 1-cycle Sb at cycle 2 after release → Ga stays on until the green run reaches 8 cycles, then Ya for 3 cycles, then Ra=Rb=1 for 1 cycle, then Gb=1 with Ra=1.
- Late Sb pulse: 1-cycle Sb after 20 green cycles → Ya=1 on the next edge.
- Return to A: after Gb is on, a 1-cycle Sa → B green lasts ≥8 cycles, then Yb for 3 cycles, all-red for 1 cycle, then Ga=1.
- Simultaneous pulses: Sa=Sb=1 together in A_GREEN → one A→B handover occurs and B stays green (reqA not set).
- Async reset mid-sequence: reset=0 asserted asynchronously during B_YELLOW, between clock edges → outputs become Ga=1, Rb=1 without waiting for an edge, and the pending requests are cleared. Throughout every scenario, check Ga&Gb never equals 1 and each road has exactly one lamp lit.
